// File: rtl/inst_fetch_stage_if.sv
// Instruction-memory bus between the fetch stage (master) and a zero-latency
// instruction memory (slave).
interface inst_fetch_stage_if #(
  parameter int unsigned INST_ADDR_WIDTH     = 16,
  parameter int unsigned INST_DATA_BIT_WIDTH = 16
);
  logic [INST_ADDR_WIDTH-1:0]     imem_addr;
  logic [INST_DATA_BIT_WIDTH-1:0] imem_data;

  modport master (output imem_addr, input imem_data);
  modport slave  (input imem_addr, output imem_data);
endinterface

// File: rtl/inst_fetch_stage.sv
// Instruction-fetch stage: owns the PC, fetches from a combinational memory and
// fills the IF/ID register; handles stall, branch redirect/flush, halt and bad fetches.
module inst_fetch_stage #(
  parameter int unsigned                   INST_ADDR_WIDTH     = 16,
  parameter int unsigned                   INST_DATA_BIT_WIDTH = 16,
  parameter int unsigned                   INST_MEM_SIZE       = 26,
  parameter logic [INST_DATA_BIT_WIDTH-1:0] HALT_WORD          = 16'hEFFF,
  parameter logic [INST_ADDR_WIDTH-1:0]     RESET_PC           = '0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           stall,
  input  logic                           branch_taken,
  input  logic [INST_ADDR_WIDTH-1:0]     branch_target,
  inst_fetch_stage_if.master             imem,
  output logic [INST_DATA_BIT_WIDTH-1:0] if_id_inst,
  output logic [INST_ADDR_WIDTH-1:0]     if_id_pc,
  output logic [INST_ADDR_WIDTH-1:0]     if_id_pc_plus2,
  output logic                           if_id_valid,
  output logic                           halted,
  output logic                           fetch_exc
);

  localparam logic [INST_ADDR_WIDTH-1:0] MemWords = INST_ADDR_WIDTH'(INST_MEM_SIZE);

  typedef enum logic [1:0] {StRun, StHalt, StExc} state_e;

  state_e                     state_q;
  logic [INST_ADDR_WIDTH-1:0] pc_q;
  logic [INST_ADDR_WIDTH-1:0] pc_plus2;
  logic                       bad_addr;

  assign imem.imem_addr = pc_q;
  assign pc_plus2       = pc_q + INST_ADDR_WIDTH'(2);
  // Odd addresses and word indices past the end of memory are both unfetchable.
  assign bad_addr       = pc_q[0] | ({1'b0, pc_q[INST_ADDR_WIDTH-1:1]} >= MemWords);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= StRun;
      pc_q           <= RESET_PC;
      if_id_inst     <= '0;
      if_id_pc       <= '0;
      if_id_pc_plus2 <= '0;
      if_id_valid    <= 1'b0;
      halted         <= 1'b0;
      fetch_exc      <= 1'b0;
    end else if (branch_taken) begin
      // Redirect also clears HALT/EXC: whatever stopped fetch was on the wrong path.
      state_q     <= StRun;
      pc_q        <= branch_target;
      if_id_inst  <= '0;
      if_id_valid <= 1'b0;
      halted      <= 1'b0;
      fetch_exc   <= 1'b0;
    end else if (!stall) begin
      unique case (state_q)
        StRun: begin
          if (bad_addr) begin
            state_q     <= StExc;
            fetch_exc   <= 1'b1;
            if_id_inst  <= '0;
            if_id_valid <= 1'b0;
          end else begin
            if_id_inst     <= imem.imem_data;
            if_id_pc       <= pc_q;
            if_id_pc_plus2 <= pc_plus2;
            if_id_valid    <= 1'b1;
            if (imem.imem_data == HALT_WORD) begin
              state_q <= StHalt;
              halted  <= 1'b1;
            end else begin
              pc_q <= pc_plus2;
            end
          end
        end
        StHalt, StExc: begin
          // Bubbles only, so the halt word reaches decode exactly once.
          if_id_valid <= 1'b0;
        end
        default: begin
          state_q <= StRun;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch_stage.sv
// Directed plus randomized bench for inst_fetch_stage against a cycle-level
// behavioural model of the fetch rules.
module tb_inst_fetch_stage;

  localparam int unsigned MemSize = 26;
  localparam logic [15:0] HaltWord = 16'hEFFF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [15:0] branch_target = '0;
  logic [15:0] if_id_inst;
  logic [15:0] if_id_pc;
  logic [15:0] if_id_pc_plus2;
  logic        if_id_valid;
  logic        halted;
  logic        fetch_exc;

  logic [15:0] mem [0:31];
  logic [14:0] addr_word;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model state
  logic [15:0] m_pc, m_inst, m_ipc, m_ipc2;
  logic        m_valid, m_halted, m_exc;

  inst_fetch_stage_if #(.INST_ADDR_WIDTH(16), .INST_DATA_BIT_WIDTH(16)) imem_bus ();

  inst_fetch_stage #(
    .INST_ADDR_WIDTH    (16),
    .INST_DATA_BIT_WIDTH(16),
    .INST_MEM_SIZE      (MemSize),
    .HALT_WORD          (HaltWord),
    .RESET_PC           (16'h0000)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem          (imem_bus.master),
    .if_id_inst    (if_id_inst),
    .if_id_pc      (if_id_pc),
    .if_id_pc_plus2(if_id_pc_plus2),
    .if_id_valid   (if_id_valid),
    .halted        (halted),
    .fetch_exc     (fetch_exc)
  );

  always #5 clk = ~clk;

  // Zero-latency instruction memory
  assign addr_word = imem_bus.imem_addr[15:1];
  assign imem_bus.imem_data = (addr_word < 15'(MemSize)) ? mem[addr_word[4:0]] : 16'h0000;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] model_word(input logic [15:0] pc);
    if ((pc >> 1) < MemSize) return mem[pc[5:1]];
    return 16'h0000;
  endfunction

  task automatic model_step(input logic r, input logic s, input logic b, input logic [15:0] t);
    logic [15:0] w;
    logic        bad;
    w   = model_word(m_pc);
    bad = m_pc[0] || ((m_pc >> 1) >= MemSize);
    if (!r) begin
      m_pc = 16'h0; m_inst = 16'h0; m_ipc = 16'h0; m_ipc2 = 16'h0;
      m_valid = 1'b0; m_halted = 1'b0; m_exc = 1'b0;
    end else if (b) begin
      m_pc = t; m_valid = 1'b0; m_inst = 16'h0; m_halted = 1'b0; m_exc = 1'b0;
    end else if (s) begin
      // everything holds
    end else if (m_halted || m_exc) begin
      m_valid = 1'b0;
    end else if (bad) begin
      m_exc = 1'b1; m_valid = 1'b0; m_inst = 16'h0;
    end else begin
      m_inst = w; m_ipc = m_pc; m_ipc2 = m_pc + 16'd2; m_valid = 1'b1;
      if (w == HaltWord) m_halted = 1'b1;
      else m_pc = m_pc + 16'd2;
    end
  endtask

  task automatic compare_all();
    check_eq("imem_addr", 32'(imem_bus.imem_addr), 32'(m_pc));
    check_eq("if_id_inst", 32'(if_id_inst), 32'(m_inst));
    check_eq("if_id_pc", 32'(if_id_pc), 32'(m_ipc));
    check_eq("if_id_pc_plus2", 32'(if_id_pc_plus2), 32'(m_ipc2));
    check_eq("if_id_valid", 32'(if_id_valid), 32'(m_valid));
    check_eq("halted", 32'(halted), 32'(m_halted));
    check_eq("fetch_exc", 32'(fetch_exc), 32'(m_exc));
  endtask

  // Drive inputs away from the edge, let the edge happen, then compare.
  task automatic cycle(input logic r, input logic s, input logic b, input logic [15:0] t);
    rst_n = r; stall = s; branch_taken = b; branch_target = t;
    @(posedge clk);
    model_step(r, s, b, t);
    #1;
    compare_all();
    @(negedge clk);
  endtask

  initial begin
    logic [15:0] w;
    int          n;
    m_pc = '0; m_inst = '0; m_ipc = '0; m_ipc2 = '0;
    m_valid = 1'b0; m_halted = 1'b0; m_exc = 1'b0;
    for (int i = 0; i < 32; i++) begin
      w = 16'($urandom);
      if (w == HaltWord) w = 16'h0000;
      mem[i] = w;
    end
    mem[0]  = 16'h012F;
    mem[1]  = 16'h012E;
    mem[2]  = 16'h034C;
    mem[25] = HaltWord;

    @(negedge clk);
    // 1: reset and straight-line fetch
    cycle(1'b0, 1'b0, 1'b0, 16'h0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 16'h0);
    check_eq("t1_inst2", 32'(if_id_inst), 32'h034C);
    // 2: stall holds everything
    cycle(1'b1, 1'b1, 1'b0, 16'h0);
    cycle(1'b1, 1'b1, 1'b0, 16'h0);
    cycle(1'b1, 1'b0, 1'b0, 16'h0);
    // 3: branch wins over stall
    cycle(1'b1, 1'b1, 1'b1, 16'h0020);
    // 4: run into the halt word, bubble, then recover by branch
    n = 0;
    while (!m_halted && n < 30) begin
      cycle(1'b1, 1'b0, 1'b0, 16'h0);
      n++;
    end
    check_eq("t4_reached_halt", 32'(halted), 32'h1);
    check_eq("t4_halt_pc", 32'(imem_bus.imem_addr), 32'h0032);
    cycle(1'b1, 1'b0, 1'b0, 16'h0);
    cycle(1'b1, 1'b0, 1'b1, 16'h0000);
    cycle(1'b1, 1'b0, 1'b0, 16'h0);
    // 5: out-of-range and odd targets
    cycle(1'b1, 1'b0, 1'b1, 16'h0034);
    cycle(1'b1, 1'b0, 1'b0, 16'h0);
    cycle(1'b1, 1'b0, 1'b0, 16'h0);
    cycle(1'b1, 1'b0, 1'b1, 16'h0003);
    cycle(1'b1, 1'b0, 1'b0, 16'h0);
    check_eq("t5_odd_exc", 32'(fetch_exc), 32'h1);
    cycle(1'b1, 1'b0, 1'b1, 16'h0000);
    cycle(1'b1, 1'b0, 1'b0, 16'h0);
    // 6: reset beats stall while halted
    cycle(1'b1, 1'b0, 1'b1, 16'h0032);
    cycle(1'b1, 1'b0, 1'b0, 16'h0);
    cycle(1'b0, 1'b1, 1'b0, 16'h0);
    cycle(1'b1, 1'b0, 1'b0, 16'h0);
    cycle(1'b1, 1'b0, 1'b0, 16'h0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic        r, s, b;
      logic [15:0] t;
      r = ($urandom_range(0, 99) != 0);
      s = ($urandom_range(0, 3) == 0);
      b = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) != 0) t = 16'($urandom_range(0, MemSize - 1) * 2);
      else t = 16'($urandom);
      cycle(r, s, b, t);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/inst_fetch_stage.md
Name: inst_fetch_stage

Overview:
- Instruction-fetch stage and IF/ID pipeline register, sitting directly upstream of the instruction memory.
- Owns the program counter and drives the byte address into the combinational instruction memory.
- Captures the returned 16-bit word together with its PC into the IF/ID register for decode.
- Handles stall, taken-branch redirect/flush, the halt word 16'hEFFF, and out-of-range fetch exceptions.

Parameters:
INST_ADDR_WIDTH, 16, PC / memory address width in bits
INST_DATA_BIT_WIDTH, 16, instruction word width
INST_MEM_SIZE, 26, number of instruction words in memory (valid byte addresses 0 .. 2*INST_MEM_SIZE-2)
HALT_WORD, 16'hEFFF, instruction encoding that halts fetch
RESET_PC, 0, PC value loaded on reset

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset
stall  input  1  downstream hazard; hold PC and IF/ID
branch_taken  input  1  redirect request from execute stage
branch_target  input  INST_ADDR_WIDTH  redirect byte address
imem_addr  output  INST_ADDR_WIDTH  fetch address to instruction memory (= PC)
imem_data  input  INST_DATA_BIT_WIDTH  word returned by memory, same cycle
if_id_inst  output  INST_DATA_BIT_WIDTH  registered instruction
if_id_pc  output  INST_ADDR_WIDTH  registered PC of if_id_inst
if_id_pc_plus2  output  INST_ADDR_WIDTH  registered PC+2 (branch base)
if_id_valid  output  1  IF/ID holds a real instruction
halted  output  1  fetch stopped on HALT_WORD
fetch_exc  output  1  fetch stopped on bad address

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-low (rst_n).
- Reset: rst_n=0 at an edge sets the following, overriding every other input in every state:
  - PC=RESET_PC
  - if_id_inst=0, if_id_pc=0, if_id_pc_plus2=0, if_id_valid=0
  - halted=0, fetch_exc=0, state=RUN
- Addressing and arithmetic:
  - imem_addr is the PC register driven combinationally.
  - imem_data is used in the same cycle (zero-latency memory).
  - PC+2 wraps modulo 2^INST_ADDR_WIDTH.
- bad_addr (combinational) = PC[0]==1 OR (PC>>1) >= INST_MEM_SIZE.
- States: RUN, HALT, EXC. The outputs halted and fetch_exc are registered and equal (state==HALT) and (state==EXC) respectively.
- Priority each edge: reset > branch_taken > stall > normal.
- branch_taken=1, any state:
  - PC<=branch_target.
  - IF/ID flushed: valid<=0, inst<=0; if_id_pc and if_id_pc_plus2 hold.
  - state<=RUN. This also recovers from HALT/EXC, because the halt or bad fetch was on the wrong path.
- stall=1, no branch: PC, IF/ID and state all hold.
- RUN, normal cycle, bad_addr=1:
  - state<=EXC, PC holds, IF/ID valid<=0, inst<=0.
  - imem_data is ignored.
- RUN, normal cycle, imem_data==HALT_WORD:
  - IF/ID loads the word, pc, pc+2, valid<=1.
  - PC holds and state<=HALT.
- RUN, normal cycle, other words:
  - IF/ID loads imem_data, PC, PC+2, valid<=1.
  - PC<=PC+2.
- HALT or EXC, normal cycle: PC holds and IF/ID valid<=0 (bubbles), so the halt word is delivered exactly once.
- Simultaneous branch_taken and bad_addr/halt in the same cycle: the branch wins and the current fetch is discarded.
- A branch to a bad target is detected on the following cycle; fetch_exc rises one cycle later.

Test Plan:
1. Reset, then 3 unstalled cycles with mem[0..2]=012F,012E,034C -> imem_addr 0x00,0x02,0x04,0x06. if_id_pc 0x00,0x02,0x04 with matching inst. if_id_valid=1 from the first post-reset edge. if_id_pc_plus2=if_id_pc+2.
2. stall=1 for 2 cycles while PC=0x06 -> imem_addr stays 0x06. IF/ID holds inst 034C / pc 0x04 / valid 1. Release stall -> next edge loads pc 0x06.
3. branch_taken=1 with target 0x20 and stall=1 in the same cycle -> next cycle imem_addr=0x20, if_id_valid=0, if_id_inst=0.
4. Run to PC=0x32 holding 16'hEFFF -> edge 1 gives if_id_inst=EFFF, valid=1, halted=1, PC=0x32. Edge 2 gives valid=0 with PC still 0x32. Then branch_taken to 0x00 -> halted=0, fetching resumes at 0x00.
5. Branch to 0x34 (INST_MEM_SIZE=26) -> the next edge sets fetch_exc=1, valid=0, PC held at 0x34. Repeat with odd target 0x03 -> same result. Branch to 0x00 -> fetch_exc=0.
6. rst_n=0 for one edge while in HALT with stall=1 -> all outputs take reset values, PC=RESET_PC. Fetch restarts at 0x00 on the next edge after release.
